// File: rtl/pattern_scan_ctrl.sv
// Serial scan sequencer for the "0 then 1" pattern detector.
// Feeds a word MSB first, one bit per DIV cycles, and counts hits.
module pattern_scan_ctrl #(
    parameter int W     = 8,
    parameter int DIV   = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    output logic             det_a,
    output logic             det_en,
    output logic             det_clear,
    input  logic             det_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic             busy
);

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BIT_W = $clog2(W + 1);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(DIV - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        SHIFT = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t           state, state_n;
    logic [W-1:0]     sreg, sreg_n;
    logic [DIV_W-1:0] div, div_n;
    logic [BIT_W-1:0] bcnt, bcnt_n;
    logic             en_d;

    assign det_a    = sreg[W-1];
    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // State register; reset abandons any partial word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next state plus the shift register, divider and bit counter updates.
    always_comb begin
        state_n = state;
        sreg_n  = sreg;
        div_n   = div;
        bcnt_n  = bcnt;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    sreg_n  = in_data;
                    bcnt_n  = BIT_W'(W);
                    state_n = CLEAR;
                end
            end
            CLEAR: begin
                div_n   = '0;
                state_n = SHIFT;
            end
            SHIFT: begin
                if (div == DIV_MAX) begin
                    div_n  = '0;
                    sreg_n = {sreg[W-2:0], 1'b0};
                    bcnt_n = bcnt - BIT_W'(1);
                    if (bcnt == BIT_W'(1)) state_n = DRAIN;
                end else begin
                    div_n = div + DIV_W'(1);
                end
            end
            DRAIN: state_n = DONE;
            DONE: begin
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Datapath and registered outputs, derived from the next-state values
    // so every pulse lines up with the state it belongs to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sreg      <= '0;
            div       <= '0;
            bcnt      <= '0;
            det_en    <= 1'b0;
            en_d      <= 1'b0;
            det_clear <= 1'b0;
            out_valid <= 1'b0;
            out_count <= '0;
        end else begin
            sreg      <= sreg_n;
            div       <= div_n;
            bcnt      <= bcnt_n;
            det_en    <= (state_n == SHIFT) && (div_n == DIV_MAX);
            en_d      <= det_en;
            det_clear <= (state_n == CLEAR);
            out_valid <= (state_n == DONE);
            if (state == IDLE && in_valid)
                out_count <= '0;
            else if (en_d && det_y && (out_count != '1))
                out_count <= out_count + CNT_W'(1);
        end
    end

endmodule

// File: doc/pattern_scan_ctrl.md
# pattern_scan_ctrl

Sequencer that serializes a parallel word into the shared two-state-output pattern detector (the `moore_fsm` "0 then 1" detector with `en`/`a`/`y`). It accepts words on a valid/ready handshake, clears the detector, and feeds one bit per `DIV`-cycle step MSB first. It counts detector hits and returns the count on a second valid/ready handshake. It sits between the board's input source (switches or upstream logic) and the detector instance, and owns that detector's `en`, `a` and clear.

## Interface
- `W`, default 8: data word width, ≥ 2.
- `DIV`, default 4: clock cycles per bit step, ≥ 1.
- `CNT_W`, default 4: hit-count width; must hold W/2.
- `clk` input 1: clock.
- `reset` input 1: reset, asynchronous, active-high.
- `in_valid` input 1: upstream word valid.
- `in_ready` output 1: controller can accept a word.
- `in_data` input W: word to scan, MSB first.
- `det_a` output 1: serial bit to detector `a`.
- `det_en` output 1: detector step enable, one-cycle pulse per bit.
- `det_clear` output 1: one-cycle pulse, ORed with `reset` into detector reset at top level.
- `det_y` input 1: detector output.
- `out_valid` output 1: result count valid.
- `out_ready` input 1: downstream accepts the result.
- `out_count` output CNT_W: number of hits in the word.
- `busy` output 1: high in any state except IDLE.

## Operation
- States: IDLE, CLEAR, SHIFT, DRAIN, DONE.
- **IDLE:** `in_ready` = 1. When `in_valid` & `in_ready`:
  - latch `in_data` into the shift register;
  - set bit counter := W, `out_count` := 0;
  - go to CLEAR.
- **CLEAR:** `det_clear` = 1 for exactly one cycle. Divider := 0. Go to SHIFT.
- **SHIFT:**
  - `det_a` = shift-register MSB (registered value, stable for the whole step).
  - Divider counts 0..DIV-1. `det_en` = 1 only in the cycle where divider = DIV-1.
  - On that cycle's edge: shift left by 1, decrement the bit counter, wrap the divider to 0.
  - On the `det_en` cycle of the last bit, go to DRAIN.
- **Hit sampling:**
  - Register `en_d` = `det_en` delayed by one cycle.
  - In any cycle with `en_d` = 1, if `det_y` = 1, increment `out_count`.
  - The count saturates at 2^CNT_W − 1; it never wraps.
  - This samples each step's Moore output exactly once, so a hit is not double-counted even if `det_y` stays high across idle divider cycles.
  - With DIV = 1, `det_en` and `en_d` are both high every cycle during SHIFT; sampling still applies.
- **DRAIN:** one cycle; `en_d` = 1 samples the last bit's result. Go to DONE.
- **DONE:**
  - `out_valid` = 1 and `out_count` is held stable.
  - When `out_ready` = 1, go to IDLE. `out_valid` drops on that edge.
  - `in_ready` = 0 until back in IDLE; back-to-back words therefore have at least 1 IDLE cycle between them.
- **In-flight words:** `in_valid` during a busy period is ignored. Upstream must hold the word; it is not dropped because `in_ready` = 0.
- **`reset` asserted at any time, including mid-SHIFT:** immediately return to IDLE. All outputs take their reset values; the partial word is discarded.
- **Illegal state encodings:** return to IDLE.

## Timing
- **Reset values:**
  - `in_ready` = 1
  - `det_a` = 0, `det_en` = 0, `det_clear` = 0
  - `out_valid` = 0, `out_count` = 0, `busy` = 0
- **Latency:** taking the accept edge as E0:
  - CLEAR during E0→E1;
  - SHIFT for W·DIV cycles;
  - DRAIN for 1 cycle;
  - `out_valid` high after edge E(W·DIV+2). For W=8, DIV=4 that is edge 34.
- **Bit steps:** `det_en` pulses occur at cycles (1 + k·DIV + DIV−1) after E0, for k = 0..W−1. `det_a` is stable for the full step window containing each pulse.
- **Clear ordering:** `det_clear` precedes the first `det_en` by DIV cycles (1 cycle when DIV = 1).
- **Register outputs:** all outputs are registered except `det_a`, which is the shift-register MSB directly, and `in_ready`/`busy`, which are decoded from the state register. There is no combinational path from any input to any output.

## Test plan
- **Alternating word:** `in_data` = 8'b01010101, DIV = 4 → `out_count` = 4. `out_valid` rises 34 edges after the accept edge. Exactly 8 `det_en` pulses, each 4 cycles apart.
- **Zero-hit words:** words 8'h00, 8'hFF, then 8'b11110000 → `out_count` = 0 each time. 8'b00000001 → 1.
- **Clear between words:** word 8'b01010100 → count 3 (detector left in S1). Then word 8'b10000000 → count 0, proving `det_clear` pulsed before the first step.
- **Backpressure:** hold `out_ready` = 0 for 5 cycles in DONE → `out_valid` and `out_count` stay stable and `in_ready` = 0. A concurrently held `in_valid` word is accepted only after the handshake plus the IDLE cycle.
- **DIV = 1:** 8'b00110011 → count 2. `det_en` is high for 8 consecutive cycles; `out_valid` rises after edge 10.
- **Mid-scan reset:** assert `reset` during the 4th bit step → all outputs return to reset values immediately. A following word 8'b01000001 scans normally → count 2.
